player_sequence_checker: RTL and testbench

Consumer side of the game's sequence lookup: drives the step index into the sequence store, reads back the expected colour, and checks each player button press against it. One round checks steps 0..round_length in order. The block reports a single-cycle pass or fail verdict to the game controller. It sits between the debounced-button front end and the game controller, opposite the sequence store.

---
 rtl/player_sequence_checker.sv | 158 +++++++++++++++
 tb/tb_player_sequence_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/player_sequence_checker.sv
// Checks player button presses against the sequence store, one step per press.
// Optional per-press timeout is enabled by defining INPUT_TIMEOUT_EN.
module player_sequence_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       check_start,
  input  logic [3:0] round_length,
  input  logic [2:0] buttons,
  input  logic [1:0] current_sequence_number,
  output logic [3:0] sequence_count,
  output logic       busy,
  output logic       round_ok,
  output logic       round_fail,
  output logic [3:0] fail_step
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    FETCH        = 3'd1,
    WAIT_PRESS   = 3'd2,
    WAIT_RELEASE = 3'd3,
    DONE         = 3'd4
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [2:0] sync1_r, sync2_r, btn_q_r, btn_prev_r;
  logic [3:0] len_r, len_nxt_s, cnt_r, cnt_nxt_s;
  logic [3:0] fail_step_r;
  logic       busy_r, round_ok_r, round_fail_r;
  logic       fail_nxt_s, press_s, match_s, timeout_s;
  logic [2:0] exp_onehot_s;

  // Button synchroniser plus registered copy for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r    <= 3'b000;
      sync2_r    <= 3'b000;
      btn_q_r    <= 3'b000;
      btn_prev_r <= 3'b000;
    end else begin
      sync1_r    <= buttons;
      sync2_r    <= sync1_r;
      btn_q_r    <= sync2_r;
      btn_prev_r <= btn_q_r;
    end
  end

  // Colour 3 maps to no button, so every press at that step is a mismatch
  assign exp_onehot_s = (current_sequence_number == 2'd3) ? 3'b000
                      : (3'b001 << current_sequence_number);
  assign press_s = (btn_prev_r == 3'b000) && (btn_q_r != 3'b000);
  assign match_s = (exp_onehot_s != 3'b000) && (btn_q_r == exp_onehot_s);

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timer_r;

  // Per-press down-counter, reloaded on each entry to WAIT_PRESS
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_r <= {TW{1'b0}};
    end else if ((state_r != WAIT_PRESS) && (state_nxt_s == WAIT_PRESS)) begin
      timer_r <= TW'(TIMEOUT_CYCLES - 1);
    end else if ((state_r == WAIT_PRESS) && (timer_r != {TW{1'b0}})) begin
      timer_r <= timer_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      timer_r <= timer_r;
    end
  end

  assign timeout_s = (timer_r == {TW{1'b0}});
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, step counter and verdict decision
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    len_nxt_s   = len_r;
    fail_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (check_start) begin
          len_nxt_s   = round_length;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: state_nxt_s = WAIT_PRESS;
      WAIT_PRESS: begin
        if (press_s) begin
          if (match_s) begin
            state_nxt_s = WAIT_RELEASE;
          end else begin
            state_nxt_s = DONE;
            fail_nxt_s  = 1'b1;
          end
        end else if (timeout_s) begin
          state_nxt_s = DONE;
          fail_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = WAIT_PRESS;
        end
      end
      WAIT_RELEASE: begin
        if (btn_q_r == 3'b000) begin
          if (cnt_r == len_r) begin
            state_nxt_s = DONE;
          end else begin
            cnt_nxt_s   = cnt_r + 4'd1;
            state_nxt_s = FETCH;
          end
        end else begin
          state_nxt_s = WAIT_RELEASE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and registered outputs; the verdict is high for the DONE cycle only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      len_r        <= 4'd0;
      busy_r       <= 1'b0;
      round_ok_r   <= 1'b0;
      round_fail_r <= 1'b0;
      fail_step_r  <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      len_r        <= len_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
      round_ok_r   <= (state_nxt_s == DONE) && (state_r != DONE) && !fail_nxt_s;
      round_fail_r <= (state_nxt_s == DONE) && (state_r != DONE) && fail_nxt_s;
      if ((state_nxt_s == DONE) && fail_nxt_s) begin
        fail_step_r <= cnt_r;
      end else begin
        fail_step_r <= fail_step_r;
      end
    end
  end

  assign sequence_count = cnt_r;
  assign busy           = busy_r;
  assign round_ok       = round_ok_r;
  assign round_fail     = round_fail_r;
  assign fail_step      = fail_step_r;

endmodule

// File: tb/tb_player_sequence_checker.sv
// Scoreboard bench for player_sequence_checker: directed rounds push expected
// verdicts, a negedge monitor pops and checks them when a verdict pulse appears.
module tb_player_sequence_checker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       check_start = 1'b0;
  logic [3:0] round_length = 4'd0;
  logic [2:0] buttons = 3'b000;
  logic [1:0] current_sequence_number;
  logic [3:0] sequence_count;
  logic       busy, round_ok, round_fail;
  logic [3:0] fail_step;

  typedef struct {
    logic       fail;
    logic [3:0] step;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] seq_mem [16];
  int         checks = 0;
  int         passes = 0;
  logic       busy_chk = 1'b0;

  player_sequence_checker #(.TIMEOUT_CYCLES(20)) dut (
    .clock(clock), .reset_n(reset_n), .check_start(check_start),
    .round_length(round_length), .buttons(buttons),
    .current_sequence_number(current_sequence_number),
    .sequence_count(sequence_count), .busy(busy), .round_ok(round_ok),
    .round_fail(round_fail), .fail_step(fail_step)
  );

  always #5 clock = ~clock;

  // Sequence store model: registered read of the requested step
  always @(posedge clock) current_sequence_number <= seq_mem[sequence_count];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: every verdict pulse must match the head of the scoreboard
  always @(negedge clock) begin
    if (busy_chk) begin
      busy_chk = 1'b0;
      chk("busy_after_verdict", {31'd0, busy}, 32'd0);
    end
    if (reset_n && (round_ok || round_fail)) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_verdict: got ok=%0b fail=%0b, expected no pulse", round_ok, round_fail);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("verdict_fail", {31'd0, round_fail}, {31'd0, e.fail});
        chk("verdict_ok", {31'd0, round_ok}, {31'd0, !e.fail});
        chk("fail_step", {28'd0, fail_step}, {28'd0, e.step});
        chk("seq_count_at_verdict", {28'd0, sequence_count}, {28'd0, e.cnt});
        busy_chk = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [3:0] len);
    @(posedge clock); #1;
    check_start  = 1'b1;
    round_length = len;
    tick(1);
    check_start  = 1'b0;
    tick(3);
  endtask

  task automatic press(input logic [2:0] b);
    buttons = b;
    tick(6);
    buttons = 3'b000;
    tick(8);
  endtask

  task automatic push(input logic f, input logic [3:0] s, input logic [3:0] c);
    exp_t e;
    e.fail = f; e.step = s; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick(1);
      k++;
    end
    chk(name, exp_q.size(), 32'd0);
    tick(3);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seq_mem[i] = 2'd0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    chk("reset_seq_count", {28'd0, sequence_count}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_round_ok", {31'd0, round_ok}, 32'd0);
    chk("reset_round_fail", {31'd0, round_fail}, 32'd0);
    chk("reset_fail_step", {28'd0, fail_step}, 32'd0);

    // Three correct steps: colours 2,1,0
    seq_mem[0] = 2'd2; seq_mem[1] = 2'd1; seq_mem[2] = 2'd0;
    push(1'b0, 4'd0, 4'd2);
    start(4'd2);
    chk("busy_in_round", {31'd0, busy}, 32'd1);
    press(3'b100); press(3'b010); press(3'b001);
    drain("drain_three_ok");

    // Wrong colour at step 0
    seq_mem[0] = 2'd1;
    push(1'b1, 4'd0, 4'd0);
    start(4'd2);
    press(3'b100);
    drain("drain_wrong_step0");

    // Wrong colour at step 2 of a four-step round
    seq_mem[0] = 2'd0; seq_mem[1] = 2'd1; seq_mem[2] = 2'd2; seq_mem[3] = 2'd0;
    push(1'b1, 4'd2, 4'd2);
    start(4'd3);
    press(3'b001); press(3'b010); press(3'b001);
    drain("drain_wrong_step2");

    // Two buttons together
    seq_mem[0] = 2'd0;
    push(1'b1, 4'd0, 4'd0);
    start(4'd2);
    press(3'b011);
    drain("drain_two_buttons");

    // Held button never advances; check_start while busy is ignored
    seq_mem[0] = 2'd2; seq_mem[1] = 2'd0;
    push(1'b1, 4'd1, 4'd1);
    start(4'd3);
    buttons = 3'b100;
    tick(50);
    check_start = 1'b1; round_length = 4'd0;
    tick(1);
    check_start = 1'b0;
    tick(50);
    chk("held_no_advance", {28'd0, sequence_count}, 32'd0);
    chk("held_busy", {31'd0, busy}, 32'd1);
    buttons = 3'b000;
    tick(8);
    press(3'b100);
    drain("drain_held_then_wrong");

    // Full 16-step round, count must reach 15 without wrapping
    for (int i = 0; i < 16; i++) seq_mem[i] = 2'(i % 3);
    push(1'b0, 4'd1, 4'd15);
    start(4'd15);
    for (int i = 0; i < 16; i++) press(3'(1 << (i % 3)));
    drain("drain_sixteen_ok");

    // Reset in WAIT_RELEASE at step 5: immediate reset values, no verdict
    start(4'd15);
    for (int i = 0; i < 5; i++) press(3'(1 << (i % 3)));
    chk("step5_reached", {28'd0, sequence_count}, 32'd5);
    buttons = 3'(1 << (5 % 3));
    tick(6);
    reset_n = 1'b0;
    #1;
    chk("rst_seq_count", {28'd0, sequence_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fail_step", {28'd0, fail_step}, 32'd0);
    chk("rst_verdicts", {30'd0, round_ok, round_fail}, 32'd0);
    tick(2);
    buttons = 3'b000;
    reset_n = 1'b1;
    tick(20);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // No press at all
    seq_mem[0] = 2'd0;
`ifdef INPUT_TIMEOUT_EN
    push(1'b1, 4'd0, 4'd0);
    start(4'd0);
    tick(60);
    drain("drain_timeout");
`else
    start(4'd0);
    tick(60);
    chk("no_timeout_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
